// File: rtl/ysyx_25030093_bus_arbiter.sv
// N-master to single-memory-port arbiter: round-robin or fixed-priority grant,
// one outstanding transaction, optional busy-cycle timeout with error response.
module ysyx_25030093_bus_arbiter #(
    parameter int N_MST   = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_MST-1:0]           m_reqValid,
    input  logic [N_MST*AW-1:0]        m_addr,
    input  logic [N_MST*2-1:0]         m_size,
    input  logic [N_MST-1:0]           m_wen,
    input  logic [N_MST*DW-1:0]        m_wdata,
    input  logic [N_MST*DW/8-1:0]      m_wmask,
    output logic [N_MST-1:0]           m_respValid,
    output logic [DW-1:0]              m_rdata,
    output logic [N_MST-1:0]           m_err,
    output logic                       s_reqValid,
    output logic [AW-1:0]              s_addr,
    output logic [1:0]                 s_size,
    output logic                       s_wen,
    output logic [DW-1:0]              s_wdata,
    output logic [DW/8-1:0]            s_wmask,
    input  logic                       s_respValid,
    input  logic [DW-1:0]              s_rdata,
    output logic [$clog2(N_MST)-1:0]   grant_id,
    output logic                       busy
);

    localparam int GW = $clog2(N_MST);
    localparam int MW = DW / 8;
    localparam int CW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [GW-1:0]    rr_ptr;
    logic [GW-1:0]    winner;
    logic             any_req;
    logic             timeout_hit;
    logic [CW-1:0]    tmo_cnt;
    logic             err_flag;
    logic [DW-1:0]    rdata_q;
    logic [N_MST-1:0] grant_onehot;

    assign any_req     = |m_reqValid;
    assign timeout_hit = (TIMEOUT > 0) && (tmo_cnt == CW'(TIMEOUT - 1));

    // Round-robin scans offsets N..1 from the pointer so the nearest
    // requester after the last grant is assigned last and therefore wins.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        winner = '0;
        if (RR_MODE != 0) begin
            for (int k = N_MST; k >= 1; k--) begin
                if (m_reqValid[(int'(rr_ptr) + k) % N_MST])
                    winner = GW'((int'(rr_ptr) + k) % N_MST);
            end
        end else begin
            for (int i = N_MST - 1; i >= 0; i--) begin
                if (m_reqValid[i])
                    winner = GW'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (s_respValid || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, and the
    // payload registers are reset too because they drive s_* directly.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= GW'(N_MST - 1);
            s_addr   <= '0;
            s_size   <= '0;
            s_wen    <= 1'b0;
            s_wdata  <= '0;
            s_wmask  <= '0;
            rdata_q  <= '0;
            err_flag <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id <= winner;
                        rr_ptr   <= winner;
                        s_addr   <= m_addr[int'(winner)*AW +: AW];
                        s_size   <= m_size[int'(winner)*2 +: 2];
                        s_wen    <= m_wen[winner];
                        s_wdata  <= m_wdata[int'(winner)*DW +: DW];
                        s_wmask  <= m_wmask[int'(winner)*MW +: MW];
                        tmo_cnt  <= '0;
                    end
                end
                BUSY: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    // A response in the timeout cycle still counts as success.
                    if (s_respValid) begin
                        rdata_q  <= s_rdata;
                        err_flag <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q  <= '0;
                        err_flag <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant_onehot = {{(N_MST-1){1'b0}}, 1'b1} << grant_id;
    assign s_reqValid   = (state == BUSY);
    assign busy         = (state != IDLE);
    assign m_respValid  = (state == RESP) ? grant_onehot : '0;
    assign m_err        = (state == RESP && err_flag) ? grant_onehot : '0;
    assign m_rdata      = rdata_q;

endmodule

// File: tb/tb_ysyx_25030093_bus_arbiter.sv
// Directed bench for the bus arbiter: a round-robin/timeout instance (d0) and
// a fixed-priority instance (d1), with a response scoreboard per instance.
module tb_ysyx_25030093_bus_arbiter;

    typedef struct {
        int          m;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;

    logic [2:0]  req     [2];
    logic [95:0] addr    [2];
    logic [5:0]  size    [2];
    logic [2:0]  wen     [2];
    logic [95:0] wdata   [2];
    logic [11:0] wmask   [2];
    logic [2:0]  m_resp  [2];
    logic [31:0] m_rdata [2];
    logic [2:0]  m_err   [2];
    logic        s_req   [2];
    logic [31:0] s_addr  [2];
    logic [1:0]  s_size  [2];
    logic        s_wen   [2];
    logic [31:0] s_wdata [2];
    logic [3:0]  s_wmask [2];
    logic        s_resp  [2];
    logic [31:0] s_rdata [2];
    logic [1:0]  gid     [2];
    logic        busy    [2];

    logic [31:0] a_addr  [2][3];
    logic [1:0]  a_size  [2][3];
    logic        a_wen   [2][3];
    logic [31:0] a_wdata [2][3];
    logic [3:0]  a_wmask [2][3];

    exp_t sb0[$];
    exp_t sb1[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    ysyx_25030093_bus_arbiter #(
        .N_MST(3), .AW(32), .DW(32), .RR_MODE(1), .TIMEOUT(8)
    ) u_rr (
        .clock(clock), .reset(reset),
        .m_reqValid(req[0]), .m_addr(addr[0]), .m_size(size[0]), .m_wen(wen[0]),
        .m_wdata(wdata[0]), .m_wmask(wmask[0]),
        .m_respValid(m_resp[0]), .m_rdata(m_rdata[0]), .m_err(m_err[0]),
        .s_reqValid(s_req[0]), .s_addr(s_addr[0]), .s_size(s_size[0]), .s_wen(s_wen[0]),
        .s_wdata(s_wdata[0]), .s_wmask(s_wmask[0]),
        .s_respValid(s_resp[0]), .s_rdata(s_rdata[0]),
        .grant_id(gid[0]), .busy(busy[0])
    );

    ysyx_25030093_bus_arbiter #(
        .N_MST(3), .AW(32), .DW(32), .RR_MODE(0), .TIMEOUT(0)
    ) u_fp (
        .clock(clock), .reset(reset),
        .m_reqValid(req[1]), .m_addr(addr[1]), .m_size(size[1]), .m_wen(wen[1]),
        .m_wdata(wdata[1]), .m_wmask(wmask[1]),
        .m_respValid(m_resp[1]), .m_rdata(m_rdata[1]), .m_err(m_err[1]),
        .s_reqValid(s_req[1]), .s_addr(s_addr[1]), .s_size(s_size[1]), .s_wen(s_wen[1]),
        .s_wdata(s_wdata[1]), .s_wmask(s_wmask[1]),
        .s_respValid(s_resp[1]), .s_rdata(s_rdata[1]),
        .grant_id(gid[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_master(input int d, input int m, input logic r, input logic [31:0] a,
                              input logic [1:0] sz, input logic w, input logic [31:0] wd,
                              input logic [3:0] wm);
        req[d][m]           = r;
        addr[d][m*32 +: 32] = a;
        size[d][m*2 +: 2]   = sz;
        wen[d][m]           = w;
        wdata[d][m*32 +: 32] = wd;
        wmask[d][m*4 +: 4]  = wm;
        a_addr[d][m]  = a;
        a_size[d][m]  = sz;
        a_wen[d][m]   = w;
        a_wdata[d][m] = wd;
        a_wmask[d][m] = wm;
    endtask

    // Slave side of one transaction: expects master m to be granted, responds
    // in BUSY cycle 'delay' (0 = stay silent and let the timeout fire).
    task automatic serve(input int d, input int m, input int delay, input logic [31:0] rd,
                         input logic [2:0] drop_mask);
        int   k;
        int   cyc;
        exp_t e;
        bit   to;
        k = 0;
        while (s_req[d] !== 1'b1 && k < 20) begin
            @(negedge clock);
            k++;
        end
        check($sformatf("d%0d_m%0d_grant_seen", d, m), 64'(s_req[d]), 64'(1));
        check($sformatf("d%0d_m%0d_grant_id", d, m), 64'(gid[d]), 64'(m));
        to     = (delay == 0);
        e.m    = m;
        e.data = to ? 32'h0 : rd;
        e.err  = to;
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        cyc = 1;
        while (s_req[d] === 1'b1 && cyc <= 30) begin
            check($sformatf("d%0d_s_addr_c%0d", d, cyc), 64'(s_addr[d]), 64'(a_addr[d][m]));
            check($sformatf("d%0d_s_size_c%0d", d, cyc), 64'(s_size[d]), 64'(a_size[d][m]));
            check($sformatf("d%0d_s_wen_c%0d", d, cyc), 64'(s_wen[d]), 64'(a_wen[d][m]));
            check($sformatf("d%0d_s_wdata_c%0d", d, cyc), 64'(s_wdata[d]), 64'(a_wdata[d][m]));
            check($sformatf("d%0d_s_wmask_c%0d", d, cyc), 64'(s_wmask[d]), 64'(a_wmask[d][m]));
            check($sformatf("d%0d_busy_c%0d", d, cyc), 64'(busy[d]), 64'(1));
            check($sformatf("d%0d_no_resp_c%0d", d, cyc), 64'(m_resp[d]), 64'(0));
            if (cyc == delay) begin
                s_resp[d]  = 1'b1;
                s_rdata[d] = rd;
            end
            @(negedge clock);
            s_resp[d]  = 1'b0;
            s_rdata[d] = 32'hBAD0_0000 | 32'(cyc);
            cyc++;
        end
        check($sformatf("d%0d_m%0d_busy_cycles", d, m), 64'(cyc - 1), 64'(to ? 8 : delay));
        check($sformatf("d%0d_m%0d_resp_pulse", d, m), 64'(m_resp[d]), 64'(3'b001 << m));
        req[d] = req[d] & ~drop_mask;
        @(negedge clock);
        check($sformatf("d%0d_m%0d_resp_gone", d, m), 64'(m_resp[d]), 64'(0));
        check($sformatf("d%0d_m%0d_idle", d, m), 64'(busy[d]), 64'(0));
        check($sformatf("d%0d_m%0d_addr_hold", d, m), 64'(s_addr[d]), 64'(a_addr[d][m]));
    endtask

    always @(negedge clock) begin
        exp_t e;
        bit   have;
        for (int d = 0; d < 2; d++) begin
            if (m_resp[d] !== 3'b000) begin
                have = (d == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
                if (!have) begin
                    check($sformatf("d%0d_unexpected_resp", d), 64'(m_resp[d]), 64'(0));
                end else begin
                    e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                    check($sformatf("d%0d_sb_onehot", d), 64'(m_resp[d]), 64'(3'b001 << e.m));
                    check($sformatf("d%0d_sb_rdata", d), 64'(m_rdata[d]), 64'(e.data));
                    check($sformatf("d%0d_sb_err", d), 64'(m_err[d]),
                          64'(e.err ? (3'b001 << e.m) : 3'b000));
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            s_resp[d]  = 1'b0;
            s_rdata[d] = 32'h0;
            for (int m = 0; m < 3; m++)
                set_master(d, m, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 4'h0);
        end
        repeat (2) @(negedge clock);

        // Reset state of both instances
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_rst_busy", d), 64'(busy[d]), 64'(0));
            check($sformatf("d%0d_rst_gid", d), 64'(gid[d]), 64'(0));
            check($sformatf("d%0d_rst_s_req", d), 64'(s_req[d]), 64'(0));
            check($sformatf("d%0d_rst_m_resp", d), 64'(m_resp[d]), 64'(0));
            check($sformatf("d%0d_rst_m_err", d), 64'(m_err[d]), 64'(0));
            check($sformatf("d%0d_rst_m_rdata", d), 64'(m_rdata[d]), 64'(0));
            check($sformatf("d%0d_rst_s_addr", d), 64'(s_addr[d]), 64'(0));
        end
        reset = 1'b1;
        @(negedge clock);

        // Single read, response in the 3rd BUSY cycle
        set_master(0, 0, 1'b1, 32'h8000_0000, 2'd2, 1'b0, 32'h0, 4'h0);
        serve(0, 0, 3, 32'h1234_5678, 3'b001);

        // Write from master 1: payload must be stable through BUSY
        set_master(0, 1, 1'b1, 32'h8000_0100, 2'd2, 1'b1, 32'hDEAD_BEEF, 4'h3);
        serve(0, 1, 2, 32'h0000_0000, 3'b010);

        // Round-robin contention: masters 0 and 1 held high
        set_master(0, 0, 1'b1, 32'h0000_1000, 2'd1, 1'b0, 32'h0, 4'h0);
        set_master(0, 1, 1'b1, 32'h0000_2000, 2'd0, 1'b0, 32'h0, 4'h0);
        serve(0, 0, 1, 32'hA000_0001, 3'b000);
        serve(0, 1, 2, 32'hA000_0002, 3'b000);
        serve(0, 0, 1, 32'hA000_0003, 3'b000);
        serve(0, 1, 1, 32'hA000_0004, 3'b011);

        // Silent slave: timeout after 8 BUSY cycles, then a late response is ignored
        set_master(0, 2, 1'b1, 32'h0000_3000, 2'd2, 1'b0, 32'h0, 4'h0);
        serve(0, 2, 0, 32'h0, 3'b100);
        s_resp[0]  = 1'b1;
        s_rdata[0] = 32'hFFFF_FFFF;
        @(negedge clock);
        s_resp[0]  = 1'b0;
        check("d0_late_resp_busy", 64'(busy[0]), 64'(0));
        check("d0_late_resp_pulse", 64'(m_resp[0]), 64'(0));
        check("d0_late_resp_rdata", 64'(m_rdata[0]), 64'(0));
        @(negedge clock);
        check("d0_late_resp_pulse2", 64'(m_resp[0]), 64'(0));

        // Response in the same cycle as the timeout: response wins, no error
        set_master(0, 0, 1'b1, 32'h0000_4000, 2'd2, 1'b0, 32'h0, 4'h0);
        serve(0, 0, 8, 32'h0BAD_CAFE, 3'b001);

        // Fixed priority: master 0 wins while both are high
        set_master(1, 0, 1'b1, 32'h0000_5000, 2'd2, 1'b0, 32'h0, 4'h0);
        set_master(1, 1, 1'b1, 32'h0000_6000, 2'd2, 1'b1, 32'h1111_2222, 4'hF);
        serve(1, 0, 2, 32'hB000_0001, 3'b000);
        serve(1, 0, 1, 32'hB000_0002, 3'b000);
        serve(1, 0, 3, 32'hB000_0003, 3'b001);
        serve(1, 1, 12, 32'hB000_0004, 3'b010);

        // Reset during BUSY, then master 0 must win the first arbitration
        set_master(0, 1, 1'b1, 32'h0000_7000, 2'd1, 1'b1, 32'h5555_AAAA, 4'h1);
        begin
            int k;
            k = 0;
            while (s_req[0] !== 1'b1 && k < 20) begin
                @(negedge clock);
                k++;
            end
            check("d0_abort_busy_seen", 64'(s_req[0]), 64'(1));
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("d0_abort_s_req", 64'(s_req[0]), 64'(0));
        check("d0_abort_busy", 64'(busy[0]), 64'(0));
        check("d0_abort_m_resp", 64'(m_resp[0]), 64'(0));
        check("d0_abort_m_err", 64'(m_err[0]), 64'(0));
        check("d0_abort_gid", 64'(gid[0]), 64'(0));
        check("d0_abort_m_rdata", 64'(m_rdata[0]), 64'(0));
        check("d0_abort_s_addr", 64'(s_addr[0]), 64'(0));
        check("d0_abort_s_wen", 64'(s_wen[0]), 64'(0));
        check("d0_abort_s_wdata", 64'(s_wdata[0]), 64'(0));
        req[0] = 3'b000;
        @(negedge clock);
        reset = 1'b1;
        s_resp[0] = 1'b1;
        @(negedge clock);
        s_resp[0] = 1'b0;
        check("d0_stray_busy", 64'(busy[0]), 64'(0));
        check("d0_stray_pulse", 64'(m_resp[0]), 64'(0));
        set_master(0, 0, 1'b1, 32'h0000_8000, 2'd2, 1'b0, 32'h0, 4'h0);
        set_master(0, 1, 1'b1, 32'h0000_9000, 2'd2, 1'b0, 32'h0, 4'h0);
        set_master(0, 2, 1'b1, 32'h0000_A000, 2'd2, 1'b1, 32'hC0FF_EE00, 4'hC);
        serve(0, 0, 1, 32'hC000_0001, 3'b000);
        serve(0, 1, 1, 32'hC000_0002, 3'b000);
        serve(0, 2, 2, 32'hC000_0003, 3'b111);

        repeat (2) @(negedge clock);
        check("d0_sb_drained", 64'(sb0.size()), 64'(0));
        check("d1_sb_drained", 64'(sb1.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_25030093_bus_arbiter.md
YSYX_25030093_BUS_ARBITER -- requirements
Module: ysyx_25030093_bus_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- N_MST, 2: number of requesting masters, 2..8.
- AW, 32: address width.
- DW, 32: data width, multiple of 8.
- RR_MODE, 1: 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- TIMEOUT, 0: busy-cycle limit; 0 = disabled.

REQ-002 SHALL have ports (name, direction, width, meaning):
- clock, in, 1: sole clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- m_reqValid, in, N_MST: per-master request level.
- m_addr, in, N_MST*AW: packed addresses; master i at [i*AW +: AW].
- m_size, in, N_MST*2: packed access sizes.
- m_wen, in, N_MST: write enables.
- m_wdata, in, N_MST*DW: packed write data.
- m_wmask, in, N_MST*DW/8: packed byte masks.
- m_respValid, out, N_MST: one-cycle response pulse to the granted master.
- m_rdata, out, DW: read data, broadcast to all masters.
- m_err, out, N_MST: timeout error, valid with m_respValid.
- s_reqValid, out, 1: request to the single memory port.
- s_addr, out, AW: memory port address.
- s_size, out, 2: memory port access size.
- s_wen, out, 1: memory port write enable.
- s_wdata, out, DW: memory port write data.
- s_wmask, out, DW/8: memory port byte mask.
- s_respValid, in, 1: memory response pulse.
- s_rdata, in, DW: memory read data.
- grant_id, out, $clog2(N_MST): index of the last or current granted master.
- busy, out, 1: high in any state other than IDLE.

Function
REQ-003 SHALL implement states IDLE, BUSY and RESP.
REQ-004 Masters SHALL hold reqValid and payload stable until their own m_respValid pulse, then drop reqValid the following cycle.
REQ-005 In IDLE with any m_reqValid bit high, the block SHALL select a winner, latch its payload and grant_id, and enter BUSY next cycle.
REQ-006 With RR_MODE=1, the search SHALL start at (last_grant+1) mod N_MST and wrap around.
REQ-007 With RR_MODE=0, the lowest asserted index SHALL win.
REQ-008 In BUSY, s_reqValid SHALL be 1 and s_addr/s_size/s_wen/s_wdata/s_wmask SHALL equal the latched payload. Outside BUSY, s_reqValid=0 and the payload outputs hold their last values.
REQ-009 On s_respValid=1 in BUSY:
- s_rdata SHALL be registered into m_rdata.
- The state SHALL go to RESP.
- s_reqValid SHALL drop in the same edge.
REQ-010 In RESP, m_respValid[grant_id] SHALL be 1 for exactly one cycle with m_err=0, then the state SHALL return to IDLE.
REQ-011 Latency: request seen in IDLE at cycle t gives s_reqValid from t+1. s_respValid at cycle r gives m_respValid at r+1 and IDLE at r+2. Minimum back-to-back spacing is 3 cycles.
REQ-012 When TIMEOUT>0, a counter SHALL clear on BUSY entry and increment each BUSY cycle. When it reaches TIMEOUT without s_respValid:
- The state SHALL go to RESP with m_rdata=0.
- m_err[grant_id] SHALL be 1 alongside the m_respValid pulse.
REQ-013 If s_respValid and the timeout occur in the same cycle, the response SHALL win with m_err=0.
REQ-014 s_respValid outside BUSY SHALL be ignored: no state change and no m_respValid.
REQ-015 Requests arriving while BUSY or RESP SHALL wait. No request SHALL be dropped, and each master SHALL be served at most once per arbitration pass in RR mode.
REQ-016 m_respValid SHALL be one-hot or zero at all times.

Reset
REQ-017 While reset=0, asynchronously:
- State = IDLE.
- s_reqValid, m_respValid, m_err, busy = 0.
- grant_id = 0.
- m_rdata and latched payload = 0.
- Round-robin pointer = N_MST-1, so master 0 has first priority.
- Timeout counter = 0.
REQ-018 Reset asserted mid-transaction SHALL abort it without any m_respValid. A subsequent stray s_respValid SHALL be ignored per REQ-014.

Verification
REQ-019 Single read: m_reqValid=01, m_addr[0]=0x8000_0000; s_respValid at 3rd BUSY cycle with s_rdata=0x1234_5678 -> s_addr=0x8000_0000, then m_respValid=01 and m_rdata=0x1234_5678 one cycle later, busy low after.
REQ-020 Contention, RR_MODE=1: both masters held high for 4 transactions -> grant order 0,1,0,1, never two consecutive grants to one master.
REQ-021 Contention, RR_MODE=0: both held high -> master 0 granted every time, master 1 only after master 0 deasserts.
REQ-022 TIMEOUT=8, slave silent -> m_respValid[g]=1 with m_err[g]=1 and m_rdata=0 on the cycle after the 8th BUSY cycle. A late s_respValid is then ignored.
REQ-023 Write: m_wen=1, m_wmask=0x3, m_wdata=0xDEAD_BEEF -> identical values on s_* throughout BUSY, and m_respValid pulses once.
REQ-024 reset pulled low during BUSY -> all outputs 0 immediately. After release, master 0 wins the first arbitration.
